// File: rtl/csa_addsub_pipe.sv
// Pipelined carry-select adder/subtractor: L = WIDTH/BLK/BPS register stages, one beat per cycle.
// Valid/ready on both sides; a stalled output freezes the whole chain and bubbles collapse.
module csa_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4,
  parameter int BPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NB = WIDTH / BLK;
  localparam int L  = NB / BPS;

  logic [L-1:0]     v_q, v_d;
  logic [L-1:0]     c_q, c_d;
  logic [L-1:0]     adv, load;
  logic [WIDTH-1:0] res_q [L];
  logic [WIDTH-1:0] res_d [L];
  logic [WIDTH-1:0] a_q   [L];
  logic [WIDTH-1:0] a_d   [L];
  logic [WIDTH-1:0] bx_q  [L];
  logic [WIDTH-1:0] bx_d  [L];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Move-forward decisions ripple from the output back to the input stage.
  always_comb begin : ctrl
    adv      = '0;
    load     = '0;
    adv[L-1] = v_q[L-1] & out_ready;
    for (int s = L - 1; s >= 1; s--) begin
      load[s]  = ~v_q[s] | adv[s];
      adv[s-1] = v_q[s-1] & load[s];
    end
    load[0] = ~v_q[0] | adv[0];
  end

  always_comb begin : datapath
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             sv;
    logic [BLK:0]     s0;
    logic [BLK:0]     s1;
    logic [BLK:0]     sel;
    int               p;
    int               lo;

    v_d    = v_q;
    c_d    = c_q;
    res_d  = res_q;
    a_d    = a_q;
    bx_d   = bx_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;

    for (int s = 0; s < L; s++) begin
      p = (s == 0) ? 0 : s - 1;
      if (s == 0) begin
        sa = a;
        sb = b ^ {WIDTH{sub}};
        c  = sub;
        r  = '0;
        sv = in_valid;
      end else begin
        sa = a_q[p];
        sb = bx_q[p];
        c  = c_q[p];
        r  = res_q[p];
        sv = v_q[p];
      end

      // Both carry hypotheses per block; the incoming carry picks one and chains on.
      for (int j = 0; j < BPS; j++) begin
        lo  = (s * BPS + j) * BLK;
        s0  = {1'b0, sa[lo +: BLK]} + {1'b0, sb[lo +: BLK]};
        s1  = {1'b0, sa[lo +: BLK]} + {1'b0, sb[lo +: BLK]} + {{BLK{1'b0}}, 1'b1};
        sel = c ? s1 : s0;
        r[lo +: BLK] = sel[BLK-1:0];
        c   = sel[BLK];
      end

      if (load[s]) begin
        v_d[s] = sv;
      end
      if (load[s] && sv) begin
        c_d[s]   = c;
        res_d[s] = r;
        a_d[s]   = sa;
        bx_d[s]  = sb;
        if (s == L - 1) begin
          ovf_d  = (sa[WIDTH-1] == sb[WIDTH-1]) && (r[WIDTH-1] != sa[WIDTH-1]);
          zero_d = ~|r;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int s = 0; s < L; s++) begin
        res_q[s] <= '0;
        a_q[s]   <= '0;
        bx_q[s]  <= '0;
      end
    end else begin
      v_q    <= v_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      res_q  <= res_d;
      a_q    <= a_d;
      bx_q   <= bx_d;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[L-1];
  assign sum       = res_q[L-1];
  assign cout      = c_q[L-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_csa_addsub_pipe.sv
// Bench for csa_addsub_pipe: a 32-bit/4-stage instance and a 16-bit/1-stage instance
// share stimulus; sel picks which one is driven and observed.
module tb_csa_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        sub = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        ir32, ov32, co32, of32, z32;
  logic [31:0] s32;
  logic        ir16, ov16, co16, of16, z16;
  logic [15:0] s16;

  always #5 clk = ~clk;

  csa_addsub_pipe #(.WIDTH(32), .BLK(4), .BPS(2)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel), .in_ready(ir32),
    .a(a), .b(b), .sub(sub),
    .out_valid(ov32), .out_ready(out_ready),
    .sum(s32), .cout(co32), .ovf(of32), .zero(z32)
  );

  csa_addsub_pipe #(.WIDTH(16), .BLK(4), .BPS(4)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel), .in_ready(ir16),
    .a(a[15:0]), .b(b[15:0]), .sub(sub),
    .out_valid(ov16), .out_ready(out_ready),
    .sum(s16), .cout(co16), .ovf(of16), .zero(z16)
  );

  logic        o_ir, o_v;
  logic [31:0] o_sum;
  logic [2:0]  o_fl;
  assign o_ir  = sel ? ir16 : ir32;
  assign o_v   = sel ? ov16 : ov32;
  assign o_sum = sel ? {16'h0, s16} : s32;
  assign o_fl  = sel ? {co16, of16, z16} : {co32, of32, z32};

  typedef struct packed {
    logic [31:0] sum;
    logic [2:0]  fl;   // {cout, ovf, zero}
  } res_t;

  res_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] held_sum;
  logic [2:0]  held_fl;

  function automatic int lcur();
    return sel ? 1 : 4;
  endfunction

  // Arithmetic reference: plain modular add of the conditioned operands.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input int w);
    logic [63:0] mask, am, bm, tot;
    res_t r;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'h0, x} & mask;
    bm   = {32'h0, (s ? ~y : y)} & mask;
    tot  = am + bm + {63'h0, s};
    r.sum = 32'(tot & mask);
    r.fl  = {tot[w], (am[w-1] == bm[w-1]) && (tot[w-1] != am[w-1]), (tot & mask) == 64'h0};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check, update scoreboard, advance to 1 time unit after the edge.
  task automatic step(input bit inv, input logic [31:0] ia, input logic [31:0] ib,
                      input bit isub, input bit ordy, output bit acc);
    res_t e;
    in_valid  = inv;
    a         = ia;
    b         = ib;
    sub       = isub;
    out_ready = ordy;
    #1;
    chk("in_ready", o_ir, !(q.size() == lcur() && !ordy));
    if (prev_stall) begin
      chk("stall_valid", o_v, 1);
      chk("stall_sum", o_sum, held_sum);
      chk("stall_flags", o_fl, held_fl);
    end
    if (o_v && ordy) begin
      chk("unexpected_out", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sum", o_sum, e.sum);
        chk("flags", o_fl, e.fl);
      end
    end
    acc = inv && o_ir;
    if (acc) q.push_back(model(ia, ib, isub, sel ? 16 : 32));
    prev_stall = o_v && !ordy;
    held_sum   = o_sum;
    held_fl    = o_fl;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [31:0] ia, input logic [31:0] ib, input bit isub);
    bit acc;
    int lat;
    step(1'b1, ia, ib, isub, 1'b1, acc);
    chk("accept", acc, 1);
    lat = 1;
    while (!o_v && lat < 20) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc);
      lat++;
    end
    chk("latency", lat, lcur());
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc);
      n++;
    end
    chk("drained", q.size(), 0);
  endtask

  task automatic stream(input int beats);
    bit acc;
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < beats && guard < 400) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), acc);
      if (acc) sent++;
      guard++;
    end
    chk("stream_sent", sent, beats);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;

    // Reset state
    #2;
    chk("rst_valid", o_v, 0);
    chk("rst_sum", o_sum, 0);
    chk("rst_flags", o_fl, 0);
    chk("rst_in_ready", o_ir, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed 32-bit cases
    run_one(32'h0000_0005, 32'h0000_0003, 1'b0);
    run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_one(32'h8000_0000, 32'h0000_0001, 1'b1);
    run_one(32'h0000_0003, 32'h0000_0005, 1'b1);

    // Fill with output stalled: four beats held, then input must stall
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, $urandom, 1'(i & 1), 1'b0, acc);
    chk("fill_depth", q.size(), 4);
    drain();

    // Random back-to-back stream with random backpressure
    stream(20);

    // Asynchronous reset with beats in flight
    step(1'b1, 32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, acc);
    step(1'b1, 32'h0000_0033, 32'h0000_0044, 1'b0, 1'b0, acc);
    step(1'b1, 32'h0000_0055, 32'h0000_0066, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("pre_rst_valid", o_v, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", o_v, 0);
    chk("async_rst_sum", o_sum, 0);
    chk("async_rst_flags", o_fl, 0);
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    run_one(32'h0000_0010, 32'h0000_0010, 1'b1);

    // Degenerate single-stage configuration
    sel = 1'b1;
    run_one(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    run_one(32'h0000_0005, 32'h0000_0003, 1'b0);
    run_one(32'h0000_7FFF, 32'h0000_0001, 1'b0);
    run_one(32'h0000_8000, 32'h0000_0001, 1'b1);
    stream(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csa_addsub_pipe.md
Name: csa_addsub_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor for the execute-stage ALU.
- Generalises the fixed 32-bit, 4-bit-block combinational carry-select adder in four ways: configurable width, configurable block size, configurable pipeline depth, and add/subtract mode with status flags.
- Operands enter through a valid/ready handshake. A block-wise carry resolves across registered stages, and results leave through a valid/ready handshake with full backpressure.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLK.
- BLK, 4, bits per carry-select block; each block has two ripple adders (cin=0, cin=1) and a carry-steered mux.
- BPS, 2, blocks resolved per pipeline stage; NB=WIDTH/BLK must be a multiple of BPS.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts the beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  1: compute a-b; 0: compute a+b
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts the result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0

Behaviour:
- Derived constants: NB=WIDTH/BLK; latency L=NB/BPS stages; stage s resolves blocks s*BPS .. s*BPS+BPS-1.
- Operand conditioning at acceptance: bx = b ^ {WIDTH{sub}}; carry into block 0 = sub.
- Inside a stage, each block computes sum0/cout0 (cin=0) and sum1/cout1 (cin=1). The incoming carry selects between them, and the selected cout chains to the next block in the same stage.
- Stage register s holds:
  - v[s]
  - the carry out of its last block
  - result bits resolved so far
  - unresolved high slices of a and bx
  - a[WIDTH-1] and bx[WIDTH-1], needed for ovf
- Final stage (s=L-1) produces:
  - sum: all resolved bits
  - cout: carry out of block NB-1
  - ovf: (a[MSB]==bx[MSB]) && (sum[MSB]!=a[MSB])
  - zero: ~|sum
- These outputs come directly from registers; no combinational path from a/b to outputs.
- Elastic handshake:
  - adv[L-1] = out_valid && out_ready.
  - Stage s loads from stage s-1 when !v[s] || adv[s]; this is computed per stage, back to front.
  - in_ready = !v[0] || (stage 0 moves forward this cycle). in_ready must not depend on in_valid.
  - A beat is accepted when in_valid && in_ready.
  - A stage whose predecessor is empty or not moving clears its v bit on moving forward; otherwise it holds contents.
- Throughput: one result per cycle with out_ready held high. Latency from acceptance to out_valid is L cycles (4 at defaults).
- Backpressure:
  - With out_ready low, the pipeline fills and bubbles collapse.
  - in_ready goes low only when all L stages are valid and the output is stalled.
  - sum/cout/ovf/zero stay stable while out_valid && !out_ready.
- Simultaneous accept at stage 0 and move-forward out of the last stage in the same cycle is legal; no beat is lost or duplicated.
- Reset (async assert, any time including mid-stream):
  - all v[s]=0, so out_valid=0 and all in-flight beats are discarded
  - sum=0, cout=0, ovf=0, zero=0
  - in_ready=1 once reset deasserts
- Wrap-around: arithmetic is modulo 2^WIDTH; cout and ovf report the wrap, never saturate.
- Degenerate case BPS=NB: L=1, a single registered stage, still elastic.

Test Plan:
- Reset, then a=0x0000_0005, b=0x0000_0003, sub=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0x0000_0008, cout=0, ovf=0, zero=0.
- a=0xFFFF_FFFF, b=0x0000_0001, sub=0 -> sum=0x0000_0000, cout=1, ovf=0, zero=1 (carry crosses every block and stage).
- a=0x7FFF_FFFF, b=0x0000_0001, sub=0 -> sum=0x8000_0000, ovf=1, cout=0. Then a=0x8000_0000, b=0x0000_0001, sub=1 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- Back-to-back stream:
  - Setup: 20 random beats, out_ready toggled pseudo-randomly.
  - Required: results match the reference model in order, no drops or duplicates, outputs stable during stalls.
  - Required: in_ready falls only when 4 beats are held with out_ready=0.
- Stream of 3 beats, then assert rst for 1 cycle mid-flight -> out_valid=0 and sum/flags=0 immediately (asynchronous). No stale beat appears after release. Next beat a=0x10, b=0x10, sub=1 -> sum=0, zero=1, cout=1.
- Re-run the directed cases with WIDTH=16, BLK=4, BPS=4 -> latency 1 cycle. 0xFFFF+0x0001 -> sum=0x0000, cout=1, zero=1.
